// File: rtl/imm_extend_pipe.sv
// -----------------------------------------------------------------------------
// imm_extend_pipe
//   Two-stage pipelined LEGv8 immediate generator. Stage 1 captures the raw
//   immediate field selected by the format code together with the format, the
//   MOVZ/MOVK half-word select and the sideband tag. Stage 2 performs the
//   zero/sign extension and post-shift and registers the final operand.
//   A valid/ready handshake on both sides lets downstream back-pressure stall
//   the pipe without losing, duplicating or reordering entries.
//
// Parameters
//   OUT_W      result width, 32 or 64
//   TAG_W      sideband tag width (>= 1)
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous active-low reset
//   in_valid   instr/fmt/tag valid
//   in_ready   pipe can accept an input this cycle
//   in_instr   raw 32-bit instruction word
//   in_fmt     immediate format: 0 I, 1 D, 2 B, 3 CB, 4 IW, 5 SH, 6/7 illegal
//   in_tag     opaque sideband, returned with the result
//   out_valid  out_imm/out_err/out_tag valid
//   out_ready  consumer accepts the result this cycle
//   out_imm    extended immediate
//   out_err    illegal format, or IW shift beyond a 32-bit result
//   out_tag    tag of the instruction that produced out_imm
// -----------------------------------------------------------------------------
module imm_extend_pipe #(
  parameter int OUT_W = 64,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_fmt,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_imm,
  output logic             out_err,
  output logic [TAG_W-1:0] out_tag
);

  localparam int STAGES = 2;

  localparam logic [2:0] FMT_I  = 3'd0;
  localparam logic [2:0] FMT_D  = 3'd1;
  localparam logic [2:0] FMT_B  = 3'd2;
  localparam logic [2:0] FMT_CB = 3'd3;
  localparam logic [2:0] FMT_IW = 3'd4;
  localparam logic [2:0] FMT_SH = 3'd5;

  if (OUT_W != 32 && OUT_W != 64) begin : g_bad_out_w
    $error("imm_extend_pipe: OUT_W must be 32 or 64");
  end
  if (TAG_W < 1) begin : g_bad_tag_w
    $error("imm_extend_pipe: TAG_W must be >= 1");
  end

  // stage valid bits: [1] = S1, [2] = S2
  logic [STAGES:1]   r_vld_pipe;

  logic [25:0]       r_s1_field;
  logic [2:0]        r_s1_fmt;
  logic [1:0]        r_s1_hw;
  logic [TAG_W-1:0]  r_s1_tag;

  logic [OUT_W-1:0]  r_s2_imm;
  logic              r_s2_err;
  logic [TAG_W-1:0]  r_s2_tag;

  logic              w_s2_load;
  logic              w_s1_load;
  logic [25:0]       w_field;
  logic [63:0]       w_ext64;
  logic              w_err;
  logic              w_unused;

  // S2 advances when empty or drained this cycle; S1 advances when empty or
  // S2 takes its content. An empty S1 feeding a loading S2 moves a bubble
  // forward, so bubbles never sit behind a stalled full stage.
  assign w_s2_load = !r_vld_pipe[2] | out_ready;
  assign w_s1_load = !r_vld_pipe[1] | w_s2_load;
  assign in_ready  = w_s1_load;

  // Stage 1 field pick: right-aligned raw field, extension deferred to S2.
  always_comb begin
    w_field = '0;
    case (in_fmt)
      FMT_I:   w_field = {14'b0, in_instr[21:10]};
      FMT_D:   w_field = {17'b0, in_instr[20:12]};
      FMT_B:   w_field = in_instr[25:0];
      FMT_CB:  w_field = {7'b0,  in_instr[23:5]};
      FMT_IW:  w_field = {10'b0, in_instr[20:5]};
      FMT_SH:  w_field = {20'b0, in_instr[15:10]};
      default: w_field = '0;
    endcase
  end

  // Stage 2 extension. Everything is built at 64 bits and truncated to
  // OUT_W; sign-extending to 64 then truncating is identical to extending to
  // OUT_W, and a logical left shift truncates the same way.
  always_comb begin
    w_ext64 = '0;
    w_err   = 1'b0;
    case (r_s1_fmt)
      FMT_I:  w_ext64 = {52'b0, r_s1_field[11:0]};
      FMT_D:  w_ext64 = {{55{r_s1_field[8]}}, r_s1_field[8:0]};
      FMT_B:  w_ext64 = {{36{r_s1_field[25]}}, r_s1_field[25:0], 2'b00};
      FMT_CB: w_ext64 = {{43{r_s1_field[18]}}, r_s1_field[18:0], 2'b00};
      FMT_IW: begin
        // hw=2/3 would place the 16-bit lane entirely above a 32-bit result
        if (OUT_W == 32 && r_s1_hw[1]) begin
          w_err = 1'b1;
        end else begin
          w_ext64 = {48'b0, r_s1_field[15:0]} << {r_s1_hw, 4'b0000};
        end
      end
      FMT_SH: w_ext64 = {58'b0, r_s1_field[5:0]};
      default: w_err  = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_vld_pipe <= '0;
      r_s1_field <= '0;
      r_s1_fmt   <= '0;
      r_s1_hw    <= '0;
      r_s1_tag   <= '0;
      r_s2_imm   <= '0;
      r_s2_err   <= 1'b0;
      r_s2_tag   <= '0;
    end else begin
      if (w_s2_load) begin
        r_vld_pipe[2] <= r_vld_pipe[1];
        // data only moves with a real entry; bubbles leave payload untouched
        if (r_vld_pipe[1]) begin
          r_s2_imm <= w_ext64[OUT_W-1:0];
          r_s2_err <= w_err;
          r_s2_tag <= r_s1_tag;
        end
      end
      if (w_s1_load) begin
        r_vld_pipe[1] <= in_valid;
        if (in_valid) begin
          r_s1_field <= w_field;
          r_s1_fmt   <= in_fmt;
          r_s1_hw    <= in_instr[22:21];
          r_s1_tag   <= in_tag;
        end
      end
    end
  end

  assign out_valid = r_vld_pipe[2];
  assign out_imm   = r_s2_imm;
  assign out_err   = r_s2_err;
  assign out_tag   = r_s2_tag;

  // opcode bits and (for OUT_W=32) the upper extension half are don't-cares
  assign w_unused = ^{in_instr[31:26], w_ext64};

endmodule

// File: tb/tb_imm_extend_pipe.sv
module tb_imm_extend_pipe;

  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic [31:0]      in_instr;
  logic [2:0]       in_fmt;
  logic [TAG_W-1:0] in_tag;
  logic             out_ready;

  logic             in_ready_64, out_valid_64, out_err_64;
  logic [63:0]      out_imm_64;
  logic [TAG_W-1:0] out_tag_64;
  logic             in_ready_32, out_valid_32, out_err_32;
  logic [31:0]      out_imm_32;
  logic [TAG_W-1:0] out_tag_32;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imm_extend_pipe #(.OUT_W(64), .TAG_W(TAG_W)) u_dut64 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_64),
    .in_instr(in_instr), .in_fmt(in_fmt), .in_tag(in_tag),
    .out_valid(out_valid_64), .out_ready(out_ready), .out_imm(out_imm_64),
    .out_err(out_err_64), .out_tag(out_tag_64)
  );

  imm_extend_pipe #(.OUT_W(32), .TAG_W(TAG_W)) u_dut32 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_32),
    .in_instr(in_instr), .in_fmt(in_fmt), .in_tag(in_tag),
    .out_valid(out_valid_32), .out_ready(out_ready), .out_imm(out_imm_32),
    .out_err(out_err_32), .out_tag(out_tag_32)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; in_fmt = 3'd0; in_instr = 32'hFFFF_FFFF; in_tag = 4'd5;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if (out_valid_64 !== 1'b0 || out_imm_64 !== 64'd0 || out_err_64 !== 1'b0 || out_tag_64 !== '0) begin
        errors++;
        $display("FAIL reset_hold64 cyc%0d: valid=%b imm=%h err=%b tag=%h, want 0/0/0/0",
                 i, out_valid_64, out_imm_64, out_err_64, out_tag_64);
      end
      checks++;
      if (out_valid_32 !== 1'b0 || out_imm_32 !== 32'd0 || out_err_32 !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold32 cyc%0d: valid=%b imm=%h err=%b, want 0/0/0",
                 i, out_valid_32, out_imm_32, out_err_32);
      end
    end
    reset = 1'b1; in_valid = 1'b0;
    #1;
    checks++;
    if (in_ready_64 !== 1'b1 || in_ready_32 !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b/%b want 1/1", in_ready_64, in_ready_32);
    end
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if (out_valid_64 !== 1'b0 || out_valid_32 !== 1'b0) begin
        errors++;
        $display("FAIL reset_no_accept cyc%0d: out_valid=%b/%b want 0/0", i, out_valid_64, out_valid_32);
      end
    end
  endtask

  // Single isolated transactions through both widths, one per format case.
  task automatic test_formats();
    logic [2:0]  fmt [13];
    logic [31:0] ins [13];
    logic [63:0] e64 [13];
    logic        r64 [13];
    logic [31:0] e32 [13];
    logic        r32 [13];
    fmt[0]=3'd0;  ins[0]=32'hFFFF_FFFF;  e64[0]=64'h0000_0000_0000_0FFF; r64[0]=0; e32[0]=32'h0000_0FFF; r32[0]=0;
    fmt[1]=3'd1;  ins[1]=32'h801F_8FFF;  e64[1]=64'hFFFF_FFFF_FFFF_FFF8; r64[1]=0; e32[1]=32'hFFFF_FFF8; r32[1]=0;
    fmt[2]=3'd2;  ins[2]=32'h03FF_FFFF;  e64[2]=64'hFFFF_FFFF_FFFF_FFFC; r64[2]=0; e32[2]=32'hFFFF_FFFC; r32[2]=0;
    fmt[3]=3'd3;  ins[3]=32'hFF00_003F;  e64[3]=64'h0000_0000_0000_0004; r64[3]=0; e32[3]=32'h0000_0004; r32[3]=0;
    fmt[4]=3'd4;  ins[4]=32'h0077_DDE0;  e64[4]=64'hBEEF_0000_0000_0000; r64[4]=0; e32[4]=32'h0;         r32[4]=1;
    fmt[5]=3'd4;  ins[5]=32'h0022_4680;  e64[5]=64'h0000_0000_1234_0000; r64[5]=0; e32[5]=32'h1234_0000; r32[5]=0;
    fmt[6]=3'd4;  ins[6]=32'h0057_DDE0;  e64[6]=64'h0000_BEEF_0000_0000; r64[6]=0; e32[6]=32'h0;         r32[6]=1;
    fmt[7]=3'd5;  ins[7]=32'h0000_FC00;  e64[7]=64'd63;                  r64[7]=0; e32[7]=32'd63;        r32[7]=0;
    fmt[8]=3'd6;  ins[8]=32'hFFFF_FFFF;  e64[8]=64'd0;                   r64[8]=1; e32[8]=32'd0;         r32[8]=1;
    fmt[9]=3'd1;  ins[9]=32'h000F_F000;  e64[9]=64'h0000_0000_0000_00FF; r64[9]=0; e32[9]=32'h0000_00FF; r32[9]=0;
    fmt[10]=3'd3; ins[10]=32'h0080_0000; e64[10]=64'hFFFF_FFFF_FFF0_0000; r64[10]=0; e32[10]=32'hFFF0_0000; r32[10]=0;
    fmt[11]=3'd7; ins[11]=32'h1234_5678; e64[11]=64'd0;                  r64[11]=1; e32[11]=32'd0;       r32[11]=1;
    fmt[12]=3'd0; ins[12]=32'h0000_0000; e64[12]=64'd0;                  r64[12]=0; e32[12]=32'd0;       r32[12]=0;
    out_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      in_valid = 1'b1; in_fmt = fmt[i]; in_instr = ins[i]; in_tag = TAG_W'(i + 1);
      cyc();
      in_valid = 1'b0;
      checks++;
      if (out_valid_64 !== 1'b0) begin
        errors++;
        $display("FAIL fmt_latency v%0d: out_valid=%b one cycle after accept, want 0", i, out_valid_64);
      end
      cyc();
      checks++;
      if (out_valid_64 !== 1'b1 || out_imm_64 !== e64[i] || out_err_64 !== r64[i] || out_tag_64 !== TAG_W'(i + 1)) begin
        errors++;
        $display("FAIL fmt64 v%0d: valid=%b imm=%h err=%b tag=%h, want 1 %h %b %h",
                 i, out_valid_64, out_imm_64, out_err_64, out_tag_64, e64[i], r64[i], TAG_W'(i + 1));
      end
      checks++;
      if (out_valid_32 !== 1'b1 || out_imm_32 !== e32[i] || out_err_32 !== r32[i] || out_tag_32 !== TAG_W'(i + 1)) begin
        errors++;
        $display("FAIL fmt32 v%0d: valid=%b imm=%h err=%b tag=%h, want 1 %h %b %h",
                 i, out_valid_32, out_imm_32, out_err_32, out_tag_32, e32[i], r32[i], TAG_W'(i + 1));
      end
      cyc();
      checks++;
      if (out_valid_64 !== 1'b0) begin
        errors++;
        $display("FAIL fmt_single_emit v%0d: out_valid=%b after drain, want 0", i, out_valid_64);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic        pat [6];
    int          sent, emitted, occ;
    logic        prev_stall;
    logic [63:0] prev_imm;
    logic [TAG_W-1:0] prev_tag;
    logic        exp_rdy;
    pat[0]=1; pat[1]=0; pat[2]=0; pat[3]=1; pat[4]=1; pat[5]=0;
    sent = 0; emitted = 0; prev_stall = 1'b0; prev_imm = '0; prev_tag = '0;
    for (int c = 0; c < 80 && emitted < 10; c++) begin
      out_ready = pat[c % 6];
      in_valid  = (sent < 10);
      in_fmt    = 3'd0;
      in_instr  = (sent * 32'h111) << 10;
      in_tag    = TAG_W'(sent);
      #1;
      occ = sent - emitted;
      exp_rdy = !(occ == 2 && !out_ready);
      checks++;
      if (in_ready_64 !== exp_rdy) begin
        errors++;
        $display("FAIL b2b_in_ready c%0d: got %b want %b (occ=%0d out_ready=%b)", c, in_ready_64, exp_rdy, occ, out_ready);
      end
      if (prev_stall) begin
        checks++;
        if (out_valid_64 !== 1'b1 || out_imm_64 !== prev_imm || out_tag_64 !== prev_tag) begin
          errors++;
          $display("FAIL b2b_stable c%0d: valid=%b imm=%h tag=%h, want 1 %h %h",
                   c, out_valid_64, out_imm_64, out_tag_64, prev_imm, prev_tag);
        end
      end
      if (out_valid_64 === 1'b1 && out_ready) begin
        checks++;
        if (out_tag_64 !== TAG_W'(emitted) || out_imm_64 !== 64'(emitted * 32'h111)) begin
          errors++;
          $display("FAIL b2b_order: tag=%h imm=%h, want %h %h",
                   out_tag_64, out_imm_64, TAG_W'(emitted), 64'(emitted * 32'h111));
        end
        emitted++;
      end
      if (in_valid && in_ready_64 === 1'b1) sent++;
      prev_stall = (out_valid_64 === 1'b1) && !out_ready;
      prev_imm   = out_imm_64;
      prev_tag   = out_tag_64;
      cyc();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if (emitted != 10 || sent != 10) begin
      errors++;
      $display("FAIL b2b_count: sent=%0d emitted=%0d, want 10 10", sent, emitted);
    end
    cyc(); cyc();
    checks++;
    if (out_valid_64 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_no_dup: out_valid=%b tag=%h after drain, want 0", out_valid_64, out_tag_64);
    end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    in_valid = 1'b1; in_fmt = 3'd0; in_instr = 32'h0000_2800; in_tag = 4'hA;
    cyc();
    in_tag = 4'hB; in_instr = 32'h0000_2C00;
    cyc();
    in_valid = 1'b0;
    checks++;
    if (out_valid_64 !== 1'b1 || out_tag_64 !== 4'hA || in_ready_64 !== 1'b0) begin
      errors++;
      $display("FAIL mid_fill: valid=%b tag=%h in_ready=%b, want 1 a 0", out_valid_64, out_tag_64, in_ready_64);
    end
    reset = 1'b0;
    cyc();
    reset = 1'b1; out_ready = 1'b1;
    checks++;
    if (out_valid_64 !== 1'b0 || out_valid_32 !== 1'b0 || in_ready_64 !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: out_valid=%b/%b in_ready=%b, want 0/0 1", out_valid_64, out_valid_32, in_ready_64);
    end
    in_valid = 1'b1; in_fmt = 3'd0; in_instr = 32'h0000_0C00; in_tag = 4'h3;
    cyc();
    in_valid = 1'b0;
    checks++;
    if (out_valid_64 !== 1'b0) begin
      errors++;
      $display("FAIL mid_ghost: out_valid=%b tag=%h one cycle after accept, want 0", out_valid_64, out_tag_64);
    end
    cyc();
    checks++;
    if (out_valid_64 !== 1'b1 || out_tag_64 !== 4'h3 || out_imm_64 !== 64'd3) begin
      errors++;
      $display("FAIL mid_next: valid=%b tag=%h imm=%h, want 1 3 3", out_valid_64, out_tag_64, out_imm_64);
    end
    for (int i = 0; i < 4; i++) begin
      cyc();
      checks++;
      if (out_valid_64 !== 1'b0) begin
        errors++;
        $display("FAIL mid_leftover c%0d: out_valid=%b tag=%h, want 0", i, out_valid_64, out_tag_64);
      end
    end
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_instr = '0; in_fmt = '0; in_tag = '0; out_ready = 1'b1;
    #1;
    test_reset();
    test_formats();
    test_back_to_back();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
